// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and memory port of mem_arbiter.
// master = requesters plus memory model side; slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction
// fetch port (read only) and a data port; one transaction in flight at a time.
module mem_arbiter #(
  parameter int unsigned AW  = 7,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW        = 2;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          win_d_q, win_d_d;      // winner is the data port
  logic          last_d_q, last_d_d;    // last grant went to the data port
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          busy_q, busy_d;

  // Data wins if it is the only requester or if instruction was granted last.
  logic pick_d;
  assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_d_q   <= win_d_d;
      last_d_q  <= last_d_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      busy_q    <= busy_d;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d   = state_q;
    win_d_d   = win_d_q;
    last_d_d  = last_d_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          win_d_d  = pick_d;
          we_d     = pick_d && bus.d_we;
          m_addr_d = pick_d ? bus.d_addr : bus.i_addr;
          if (pick_d) m_wdata_d = bus.d_wdata;
          m_en_d   = 1'b1;
          m_we_d   = pick_d && bus.d_we;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        last_d_d = win_d_q;
        if (we_q) begin
          i_ack_d = !win_d_q;
          d_ack_d = win_d_q;
          state_d = ACK;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (win_d_q) d_rdata_d = bus.m_rdata;
          else         i_rdata_d = bus.m_rdata;
          i_ack_d = !win_d_q;
          d_ack_d = win_d_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=1 instance with a memory model
// and one LAT=3 instance whose m_rdata changes every cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(7), .DW(32)) b1 ();
  mem_arbiter_if #(.AW(7), .DW(32)) b3 ();

  mem_arbiter #(.AW(7), .DW(32), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.AW(7), .DW(32), .LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  int checks   = 0;
  int failures = 0;

  // Memory behind dut1: read data valid only in the cycle after the strobe.
  logic [31:0] mem [128];
  logic        rd_v;
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 128; a++)
        mem[a] <= (a == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(a));
      rd_v <= 1'b0;
      rd_q <= '0;
    end else begin
      rd_v <= b1.m_en && !b1.m_we;
      rd_q <= mem[b1.m_addr];
      if (b1.m_en && b1.m_we) mem[b1.m_addr] <= b1.m_wdata;
    end
  end
  assign b1.m_rdata = rd_v ? rd_q : 32'hBAD0BAD0;

  // dut3 sees a new memory value every cycle, so the capture cycle is exact.
  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign b3.m_rdata = {16'hC0DE, cyc};

  // Protocol monitor: adjacent m_en or simultaneous acks
  int   viol     = 0;
  int   men_cnt1 = 0;
  logic pen1     = 1'b0;
  logic pen3     = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.m_en && pen1) viol++;
      if (b3.m_en && pen3) viol++;
      if (b1.i_ack && b1.d_ack) viol++;
      if (b3.i_ack && b3.d_ack) viol++;
      if (b1.m_en) men_cnt1++;
    end
    pen1 = b1.m_en;
    pen3 = b3.m_en;
  end

  typedef struct {
    logic        i_req;
    logic [6:0]  i_addr;
    logic        d_req;
    logic        d_we;
    logic [6:0]  d_addr;
    logic [31:0] d_wdata;
    logic        exp_i;
    int          exp_lat;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vt [8];

  function automatic vec_t mk(input logic ir, input logic [6:0] ia, input logic dr,
                              input logic dw, input logic [6:0] da, input logic [31:0] wd,
                              input logic ei, input int el, input logic [31:0] eir,
                              input logic [31:0] edr);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = wd; v.exp_i = ei; v.exp_lat = el; v.exp_irdata = eir; v.exp_drdata = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 0; b3.i_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
  endtask

  // One table vector on dut1, starting from an IDLE cycle.
  task automatic run1(input int k);
    vec_t v;
    int   lat;
    logic got_i;
    logic exp_we;
    v = vt[k];
    exp_we = !v.exp_i && v.d_we;
    @(negedge clk);
    b1.i_req = v.i_req; b1.i_addr = v.i_addr;
    b1.d_req = v.d_req; b1.d_we = v.d_we; b1.d_addr = v.d_addr; b1.d_wdata = v.d_wdata;
    lat = 0; got_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d_m_en", k), 32'(b1.m_en), 32'd1);
        chk($sformatf("v%0d_m_addr", k), 32'(b1.m_addr), 32'(v.exp_i ? v.i_addr : v.d_addr));
        chk($sformatf("v%0d_m_we", k), 32'(b1.m_we), 32'(exp_we));
        if (exp_we) chk($sformatf("v%0d_m_wdata", k), b1.m_wdata, v.d_wdata);
      end
      if (b1.i_ack || b1.d_ack) begin
        lat = c; got_i = b1.i_ack;
        break;
      end
    end
    chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_ack_port_i", k), 32'(got_i), 32'(v.exp_i));
    chk($sformatf("v%0d_busy_at_ack", k), 32'(b1.busy), 32'd1);
    chk($sformatf("v%0d_i_rdata", k), b1.i_rdata, v.exp_irdata);
    chk($sformatf("v%0d_d_rdata", k), b1.d_rdata, v.exp_drdata);
    b1.i_req = 0; b1.d_req = 0; b1.d_we = 0;
  endtask

  // One read on dut3; rec is m_rdata seen four cycles after the request cycle.
  task automatic run3(input logic is_i, input logic [6:0] addr, output int lat,
                      output logic got_i, output logic [31:0] rec, output logic busy_ok);
    @(negedge clk);
    if (is_i) begin b3.i_req = 1; b3.i_addr = addr; end
    else begin b3.d_req = 1; b3.d_we = 0; b3.d_addr = addr; end
    lat = 0; got_i = 1'b0; rec = '0; busy_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) rec = b3.m_rdata;
      if (!b3.busy) busy_ok = 1'b0;
      if (b3.i_ack || b3.d_ack) begin
        lat = c; got_i = b3.i_ack;
        break;
      end
    end
    b3.i_req = 0; b3.d_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic        got_i, busy_ok;
    logic [31:0] rec;
    int          order [4];
    int          n;
    int          men0;

    vt[0] = mk(1, 7'd5,  0, 0, 7'd0,  32'h0,        1, 3, 32'hDEADBEEF, 32'h0);
    vt[1] = mk(0, 7'd0,  1, 1, 7'd9,  32'h12345678, 0, 2, 32'hDEADBEEF, 32'h0);
    vt[2] = mk(0, 7'd0,  1, 0, 7'd9,  32'h0,        0, 3, 32'hDEADBEEF, 32'h12345678);
    vt[3] = mk(1, 7'd3,  1, 1, 7'd9,  32'h55AA55AA, 1, 3, 32'hA5A50003, 32'h12345678);
    vt[4] = mk(1, 7'd4,  1, 1, 7'd3,  32'hCAFEF00D, 0, 2, 32'hA5A50003, 32'h12345678);
    vt[5] = mk(1, 7'd3,  1, 0, 7'd7,  32'h0,        1, 3, 32'hCAFEF00D, 32'h12345678);
    vt[6] = mk(1, 7'h7F, 0, 0, 7'd0,  32'h0,        1, 3, 32'hA5A5007F, 32'h12345678);
    vt[7] = mk(0, 7'd0,  1, 0, 7'd9,  32'h0,        0, 3, 32'hA5A5007F, 32'h12345678);

    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_i_ack",   32'(b1.i_ack),  32'd0);
    chk("rst_d_ack",   32'(b1.d_ack),  32'd0);
    chk("rst_m_en",    32'(b1.m_en),   32'd0);
    chk("rst_m_we",    32'(b1.m_we),   32'd0);
    chk("rst_busy",    32'(b1.busy),   32'd0);
    chk("rst_m_addr",  32'(b1.m_addr), 32'd0);
    chk("rst_m_wdata", b1.m_wdata,     32'd0);
    chk("rst_i_rdata", b1.i_rdata,     32'd0);
    chk("rst_d_rdata", b1.d_rdata,     32'd0);
    rst = 0;

    for (int k = 0; k < 8; k++) run1(k);

    // Request dropped during ISSUE still completes with a single strobe
    @(negedge clk);
    b1.i_req = 1; b1.i_addr = 7'd6;
    men0 = men_cnt1;
    @(negedge clk);
    b1.i_req = 0;
    lat = 0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (b1.i_ack || b1.d_ack) begin lat = c; break; end
    end
    chk("drop_latency", 32'(lat), 32'd3);
    chk("drop_i_rdata", b1.i_rdata, 32'hA5A50006);
    repeat (3) @(negedge clk);
    chk("drop_m_en_count", 32'(men_cnt1 - men0), 32'd1);
    chk("drop_busy_idle", 32'(b1.busy), 32'd0);

    // Both requesters held from the first cycle after reset alternate I, D, I, D
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    b1.i_req = 1; b1.i_addr = 7'd1; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 7'd2;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (b1.i_ack) begin order[n] = 0; n++; end
      else if (b1.d_ack) begin order[n] = 1; n++; end
    end
    b1.i_req = 0; b1.d_req = 0;
    chk("rr_count", 32'(n), 32'd4);
    for (int j = 0; j < n; j++) chk($sformatf("rr_order%0d", j), 32'(order[j]), 32'(j % 2));
    chk("rr_i_rdata", b1.i_rdata, 32'hA5A50001);
    chk("rr_d_rdata", b1.d_rdata, 32'hA5A50002);

    // LAT=3 data read
    run3(1'b0, 7'd2, lat, got_i, rec, busy_ok);
    chk("lat3_d_latency", 32'(lat), 32'd5);
    chk("lat3_d_port_i", 32'(got_i), 32'd0);
    chk("lat3_d_rdata", b3.d_rdata, rec);
    chk("lat3_busy_during", 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk("lat3_busy_after", 32'(b3.busy), 32'd0);

    // LAT=3 instruction read to give i_rdata a nonzero value
    run3(1'b1, 7'd1, lat, got_i, rec, busy_ok);
    chk("lat3_i_latency", 32'(lat), 32'd5);
    chk("lat3_i_rdata", b3.i_rdata, rec);

    // Reset during WAIT aborts the read
    @(negedge clk);
    b3.i_req = 1; b3.i_addr = 7'd4;
    repeat (2) @(negedge clk);
    rst = 1; b3.i_req = 0;
    @(negedge clk);
    chk("abort_i_ack", 32'(b3.i_ack), 32'd0);
    chk("abort_i_rdata", b3.i_rdata, 32'd0);
    chk("abort_busy", 32'(b3.busy), 32'd0);
    chk("abort_m_en", 32'(b3.m_en), 32'd0);
    rst = 0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b3.i_ack || b3.m_en) n++;
    end
    chk("abort_quiet", 32'(n), 32'd0);

    run3(1'b1, 7'd4, lat, got_i, rec, busy_ok);
    chk("after_abort_latency", 32'(lat), 32'd5);
    chk("after_abort_port_i", 32'(got_i), 32'd1);
    chk("after_abort_i_rdata", b3.i_rdata, rec);

    repeat (3) @(negedge clk);
    chk("protocol_violations", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
